// File: rtl/zigzag_agu.sv
// zigzag_agu
// Zig-zag / raster address generator for the bit-serial multiplier datapath.
// Walks every (weight-bit, data-bit) pair of a pw x pd precision grid and
// emits weight/data addresses (base + offset*stride, built incrementally),
// with end-of-diagonal (eod) and end-of-pass (eop) flags. A job runs nrep+1
// passes, then pulses done for one cycle.
//
// Ports:
//   clk, clr               clock, synchronous active-high reset
//   start                  job start pulse (taken only when not busy)
//   mode                   0 = anti-diagonal zig-zag, 1 = raster
//   pw, pd                 weight / data precision (0 -> zero-beat job)
//   basew, based           weight / data base addresses
//   stridew, strided       address step per bit offset
//   nrep                   extra passes
//   busy                   job in progress (RUN state)
//   out_valid, out_ready   beat handshake
//   offw, offd             bit offsets of current beat
//   addrw, addrd           addresses of current beat
//   eod, eop               last beat of diagonal/row, last beat of pass
//   done                   one-cycle pulse after the final beat of a job
//   dbg_state              FSM state (0 idle, 1 run, 2 done)
//
// Handshake: a beat transfers on a rising edge where out_valid & out_ready are
// both high; while out_valid is high and out_ready low every beat output holds.
module zigzag_agu #(
  parameter int BWADDR = 21,
  parameter int BPREC  = 4,
  parameter int BREP   = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              mode,
  input  logic [BPREC-1:0]  pw,
  input  logic [BPREC-1:0]  pd,
  input  logic [BWADDR-1:0] basew,
  input  logic [BWADDR-1:0] based,
  input  logic [BWADDR-1:0] stridew,
  input  logic [BWADDR-1:0] strided,
  input  logic [BREP-1:0]   nrep,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BPREC-1:0]  offw,
  output logic [BPREC-1:0]  offd,
  output logic [BWADDR-1:0] addrw,
  output logic [BWADDR-1:0] addrd,
  output logic              eod,
  output logic              eop,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [BPREC-1:0] ONE_P = 1;
  localparam logic [BPREC:0]   ONE_D = 1;
  localparam logic [BPREC:0]   TWO_D = 2;
  localparam logic [BREP-1:0]  ONE_R = 1;

  logic [1:0]        state_q, state_d;
  logic              busy_q, busy_d, valid_q, valid_d, done_q, done_d;
  logic              mode_q, mode_d;
  logic [BPREC-1:0]  pw_q, pw_d, pd_q, pd_d;
  logic [BWADDR-1:0] basew_q, basew_d, based_q, based_d;
  logic [BWADDR-1:0] stridew_q, stridew_d, strided_q, strided_d;
  logic [BREP-1:0]   nrep_q, nrep_d, rep_q, rep_d;
  logic [BPREC-1:0]  offw_q, offw_d, offd_q, offd_d;
  logic [BWADDR-1:0] addrw_q, addrw_d, addrd_q, addrd_d;
  // First beat of the current diagonal (zig-zag) or row (raster) and its
  // addresses; the next diagonal/row start is one stride step away from it.
  logic [BPREC-1:0]  sw_q, sw_d, sd_q, sd_d;
  logic [BWADDR-1:0] saw_q, saw_d, sad_q, sad_d;
  // Diagonal index offw+offd, one bit wider so 2*(2^BPREC-1)-2 fits.
  logic [BPREC:0]    diag_q, diag_d;
  logic              eod_q, eod_d, eop_q, eop_d;

  // Flags of a beat at (o_w, o_d) on diagonal dg: {eod, eop}.
  function automatic logic [1:0] beat_flags(input logic m,
                                            input logic [BPREC-1:0] p_w,
                                            input logic [BPREC-1:0] p_d,
                                            input logic [BPREC-1:0] o_w,
                                            input logic [BPREC-1:0] o_d,
                                            input logic [BPREC:0] dg);
    logic last_w, last_d, f_eod, f_eop;
    last_w = (o_w == p_w - ONE_P);
    last_d = (o_d == p_d - ONE_P);
    if (m) begin
      f_eod = last_w;
      f_eop = last_w & last_d;
    end else begin
      // A diagonal ends when offd reaches the top row or offw reaches 0.
      f_eod = last_d | (o_w == '0);
      f_eop = (dg == ({1'b0, p_w} + {1'b0, p_d} - TWO_D));
    end
    return {f_eod, f_eop};
  endfunction

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    mode_d    = mode_q;
    pw_d      = pw_q;
    pd_d      = pd_q;
    basew_d   = basew_q;
    based_d   = based_q;
    stridew_d = stridew_q;
    strided_d = strided_q;
    nrep_d    = nrep_q;
    rep_d     = rep_q;
    offw_d    = offw_q;
    offd_d    = offd_q;
    addrw_d   = addrw_q;
    addrd_d   = addrd_q;
    sw_d      = sw_q;
    sd_d      = sd_q;
    saw_d     = saw_q;
    sad_d     = sad_q;
    diag_d    = diag_q;
    eod_d     = eod_q;
    eop_d     = eop_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        if (start) begin
          mode_d    = mode;
          pw_d      = pw;
          pd_d      = pd;
          basew_d   = basew;
          based_d   = based;
          stridew_d = stridew;
          strided_d = strided;
          nrep_d    = nrep;
          rep_d     = '0;
          if (pw == '0 || pd == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d        = ST_RUN;
            busy_d         = 1'b1;
            valid_d        = 1'b1;
            offw_d         = '0;
            offd_d         = '0;
            addrw_d        = basew;
            addrd_d        = based;
            sw_d           = '0;
            sd_d           = '0;
            saw_d          = basew;
            sad_d          = based;
            diag_d         = '0;
            {eod_d, eop_d} = beat_flags(mode, pw, pd, '0, '0, '0);
          end
        end
      end

      ST_RUN: begin
        if (out_ready) begin
          if (eop_q) begin
            if (rep_q == nrep_q) begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              valid_d = 1'b0;
              done_d  = 1'b1;
              eod_d   = 1'b0;
              eop_d   = 1'b0;
            end else begin
              // Next pass starts again from the bases, back-to-back.
              rep_d          = rep_q + ONE_R;
              offw_d         = '0;
              offd_d         = '0;
              addrw_d        = basew_q;
              addrd_d        = based_q;
              sw_d           = '0;
              sd_d           = '0;
              saw_d          = basew_q;
              sad_d          = based_q;
              diag_d         = '0;
              {eod_d, eop_d} = beat_flags(mode_q, pw_q, pd_q, '0, '0, '0);
            end
          end else begin
            if (eod_q) begin
              if (!mode_q && (sw_q != pw_q - ONE_P)) begin
                // Diagonals start along offd=0 until offw reaches pw-1.
                sw_d  = sw_q + ONE_P;
                saw_d = saw_q + stridew_q;
              end else begin
                // Then (and for every raster row) move up one data bit.
                sd_d  = sd_q + ONE_P;
                sad_d = sad_q + strided_q;
              end
              offw_d  = sw_d;
              offd_d  = sd_d;
              addrw_d = saw_d;
              addrd_d = sad_d;
              if (!mode_q) diag_d = diag_q + ONE_D;
            end else if (!mode_q) begin
              offw_d  = offw_q - ONE_P;
              offd_d  = offd_q + ONE_P;
              addrw_d = addrw_q - stridew_q;
              addrd_d = addrd_q + strided_q;
            end else begin
              offw_d  = offw_q + ONE_P;
              addrw_d = addrw_q + stridew_q;
            end
            {eod_d, eop_d} = beat_flags(mode_q, pw_q, pd_q, offw_d, offd_d, diag_d);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      mode_q    <= 1'b0;
      pw_q      <= '0;
      pd_q      <= '0;
      basew_q   <= '0;
      based_q   <= '0;
      stridew_q <= '0;
      strided_q <= '0;
      nrep_q    <= '0;
      rep_q     <= '0;
      offw_q    <= '0;
      offd_q    <= '0;
      addrw_q   <= '0;
      addrd_q   <= '0;
      sw_q      <= '0;
      sd_q      <= '0;
      saw_q     <= '0;
      sad_q     <= '0;
      diag_q    <= '0;
      eod_q     <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      mode_q    <= mode_d;
      pw_q      <= pw_d;
      pd_q      <= pd_d;
      basew_q   <= basew_d;
      based_q   <= based_d;
      stridew_q <= stridew_d;
      strided_q <= strided_d;
      nrep_q    <= nrep_d;
      rep_q     <= rep_d;
      offw_q    <= offw_d;
      offd_q    <= offd_d;
      addrw_q   <= addrw_d;
      addrd_q   <= addrd_d;
      sw_q      <= sw_d;
      sd_q      <= sd_d;
      saw_q     <= saw_d;
      sad_q     <= sad_d;
      diag_q    <= diag_d;
      eod_q     <= eod_d;
      eop_q     <= eop_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign done      = done_q;
  assign offw      = offw_q;
  assign offd      = offd_q;
  assign addrw     = addrw_q;
  assign addrd     = addrd_q;
  assign eod       = eod_q;
  assign eop       = eop_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_zigzag_agu.sv
// tb_zigzag_agu
// Bench for zigzag_agu: a behavioural model enumerates the expected beat list
// of each job straight from the grid-walk rules, and a negedge monitor checks
// busy/out_valid/done every cycle and every presented beat against it.
module tb_zigzag_agu;

  typedef struct packed {
    logic [3:0]  ow;
    logic [3:0]  od;
    logic [20:0] aw;
    logic [20:0] ad;
    logic        eod;
    logic        eop;
    logic        last;
  } beat_t;
  localparam int W = $bits(beat_t);

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  pw = '0, pd = '0;
  logic [20:0] basew = '0, based = '0, stridew = '0, strided = '0;
  logic [7:0]  nrep = '0;
  logic        out_ready = 1'b1;
  logic        busy, out_valid, eod, eop, done;
  logic [3:0]  offw, offd;
  logic [20:0] addrw, addrd;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  zigzag_agu #(.BWADDR(21), .BPREC(4), .BREP(8)) dut (
    .clk(clk), .clr(clr), .start(start), .mode(mode), .pw(pw), .pd(pd),
    .basew(basew), .based(based), .stridew(stridew), .strided(strided),
    .nrep(nrep), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .offw(offw), .offd(offd), .addrw(addrw), .addrd(addrd),
    .eod(eod), .eop(eop), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  beat_t gen_q[$];
  bit exp_busy = 0, exp_done = 0, exp_zero = 0;
  bit start_job = 0, start_zero = 0, rand_ready = 0;
  int beats_job = 0, eops_job = 0, jobs_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic beat_t mk(input int w, input int d, input int p_w, input int p_d,
                               input logic [20:0] bw, input logic [20:0] bd,
                               input logic [20:0] sw, input logic [20:0] sd,
                               input bit e, input bit lastpass);
    beat_t b;
    longint aw, ad;
    aw = longint'(bw) + longint'(w) * longint'(sw);
    ad = longint'(bd) + longint'(d) * longint'(sd);
    b.ow = 4'(w);
    b.od = 4'(d);
    b.aw = 21'(aw);
    b.ad = 21'(ad);
    b.eod = e;
    b.eop = (w == p_w - 1) && (d == p_d - 1);
    b.last = b.eop && lastpass;
    return b;
  endfunction

  task automatic gen(input bit m, input int p_w, input int p_d,
                     input logic [20:0] bw, input logic [20:0] bd,
                     input logic [20:0] sw, input logic [20:0] sd, input int nr);
    int lo, hi;
    gen_q.delete();
    if (p_w == 0 || p_d == 0) return;
    for (int r = 0; r <= nr; r++) begin
      if (!m) begin
        for (int s = 0; s <= p_w + p_d - 2; s++) begin
          lo = (s - p_w + 1 > 0) ? s - p_w + 1 : 0;
          hi = (s < p_d - 1) ? s : p_d - 1;
          for (int d = lo; d <= hi; d++)
            gen_q.push_back(mk(s - d, d, p_w, p_d, bw, bd, sw, sd, d == hi, r == nr));
        end
      end else begin
        for (int d = 0; d < p_d; d++)
          for (int w = 0; w < p_w; w++)
            gen_q.push_back(mk(w, d, p_w, p_d, bw, bd, sw, sd, w == p_w - 1, r == nr));
      end
    end
  endtask

  // ---------------- monitor / compare ----------------
  always @(negedge clk) begin
    beat_t h;
    bit nb, nd;
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("out_valid", 32'(out_valid), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    if (exp_zero) begin
      chk("clr offw", 32'(offw), 32'd0);
      chk("clr offd", 32'(offd), 32'd0);
      chk("clr addrw", 32'(addrw), 32'd0);
      chk("clr addrd", 32'(addrd), 32'd0);
      chk("clr eod", 32'(eod), 32'd0);
      chk("clr eop", 32'(eop), 32'd0);
    end
    if (exp_busy && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("beat beyond model", 32'(out_valid), 32'd0);
      end else begin
        h = exp_q[0];
        chk("offw", 32'(offw), 32'(h.ow));
        chk("offd", 32'(offd), 32'(h.od));
        chk("addrw", 32'(addrw), 32'(h.aw));
        chk("addrd", 32'(addrd), 32'(h.ad));
        chk("eod", 32'(eod), 32'(h.eod));
        chk("eop", 32'(eop), 32'(h.eop));
      end
    end
    // Predict the next cycle from the upcoming edge's inputs.
    nb = exp_busy;
    nd = 1'b0;
    exp_zero = 1'b0;
    if (clr) begin
      exp_q.delete();
      nb = 1'b0;
      exp_zero = 1'b1;
    end else begin
      if (exp_busy && out_ready && exp_q.size() > 0) begin
        h = exp_q.pop_front();
        beats_job++;
        if (h.eop) eops_job++;
        if (h.last) begin
          nb = 1'b0;
          nd = 1'b1;
          jobs_done++;
        end
      end
      if (start && start_job) nb = 1'b1;
      if (start && start_zero) nd = 1'b1;
    end
    exp_busy = nb;
    exp_done = nd;
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input bit m, input int p_w, input int p_d,
                        input logic [20:0] bw, input logic [20:0] bd,
                        input logic [20:0] sw, input logic [20:0] sd,
                        input int nr, output int n);
    gen(m, p_w, p_d, bw, bd, sw, sd, nr);
    n = gen_q.size();
    foreach (gen_q[i]) exp_q.push_back(gen_q[i]);
    mode = m; pw = 4'(p_w); pd = 4'(p_d);
    basew = bw; based = bd; stridew = sw; strided = sd; nrep = 8'(nr);
    beats_job = 0;
    eops_job = 0;
    start = 1'b1;
    start_job = (n > 0);
    start_zero = (n == 0);
    step();
    start = 1'b0;
    start_job = 1'b0;
    start_zero = 1'b0;
    // Scramble the job inputs: the running job must use its latched copy.
    mode = 1'($urandom); pw = 4'($urandom); pd = 4'($urandom);
    basew = 21'($urandom); based = 21'($urandom);
    stridew = 21'($urandom); strided = 21'($urandom); nrep = 8'($urandom);
  endtask

  task automatic wait_job(input int n, input string tag);
    int jd, cyc;
    jd = jobs_done;
    cyc = 0;
    while (jobs_done == jd && cyc < 5000) begin
      step();
      cyc++;
    end
    if (jobs_done == jd) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no job end after %0d cycles", tag, cyc);
    end
    chk({tag, " beats"}, 32'(beats_job), 32'(n));
  endtask

  // ---------------- stimulus ----------------
  int lw[24] = '{0,1,0,2,1,0,3,2,1,0,4,3,2,1,5,4,3,2,5,4,3,5,4,5};
  int ld[24] = '{0,0,1,0,1,2,0,1,2,3,0,1,2,3,0,1,2,3,1,2,3,2,3,3};
  int raw[6] = '{100,102,104,100,102,104};
  int rad[6] = '{32'h1FFFFF,32'h1FFFFF,32'h1FFFFF,0,0,0};

  initial begin
    int n, ne, np, cyc;
    repeat (3) step();
    clr = 1'b0;
    step();

    // Pin the model with hand-derived sequences.
    gen(1'b0, 6, 4, 21'd0, 21'd0, 21'd1, 21'd1, 0);
    chk("pin zz size", 32'(gen_q.size()), 32'd24);
    ne = 0; np = 0;
    foreach (gen_q[i]) begin
      chk("pin zz offw", 32'(gen_q[i].ow), 32'(lw[i]));
      chk("pin zz offd", 32'(gen_q[i].od), 32'(ld[i]));
      ne += int'(gen_q[i].eod);
      np += int'(gen_q[i].eop);
    end
    chk("pin zz eod count", 32'(ne), 32'd9);
    chk("pin zz eop count", 32'(np), 32'd1);
    chk("pin zz eop pos", 32'(gen_q[23].eop), 32'd1);
    gen(1'b1, 3, 2, 21'd100, 21'h1FFFFF, 21'd2, 21'd1, 0);
    foreach (gen_q[i]) begin
      chk("pin rs addrw", 32'(gen_q[i].aw), 32'(raw[i]));
      chk("pin rs addrd", 32'(gen_q[i].ad), 32'(rad[i]));
      chk("pin rs eod", 32'(gen_q[i].eod), 32'(i == 2 || i == 5));
    end

    // 6x4 zig-zag, always ready.
    launch(1'b0, 6, 4, 21'h01000, 21'h1F000, 21'h00010, 21'h00400, 0, n);
    wait_job(n, "zz6x4");
    step();

    // 3x2 raster with data address wrap.
    launch(1'b1, 3, 2, 21'd100, 21'h1FFFFF, 21'd2, 21'd1, 0, n);
    wait_job(n, "raster3x2");
    step();

    // 2x2 with two extra passes: back-to-back passes, single done.
    launch(1'b0, 2, 2, 21'h00123, 21'h00456, 21'h00007, 21'h00009, 2, n);
    wait_job(n, "rep2x2");
    chk("rep2x2 beats literal", 32'(beats_job), 32'd12);
    chk("rep2x2 eops", 32'(eops_job), 32'd3);
    step();

    // 6x4 zig-zag with random stalls.
    rand_ready = 1;
    launch(1'b0, 6, 4, 21'($urandom), 21'($urandom), 21'($urandom), 21'($urandom), 0, n);
    wait_job(n, "zz6x4 stall");
    rand_ready = 0;
    step();

    // Zero-beat job, then start held while busy, then start during done.
    launch(1'b0, 0, 5, 21'd1, 21'd2, 21'd3, 21'd4, 0, n);
    step();
    step();
    launch(1'b1, 0, 0, 21'd1, 21'd2, 21'd3, 21'd4, 1, n);
    step();
    launch(1'b0, 6, 4, 21'h00aaa, 21'h00bbb, 21'h00011, 21'h00022, 0, n);
    start = 1'b1;
    repeat (5) step();
    start = 1'b0;
    wait_job(n, "held start");
    launch(1'b1, 5, 3, 21'h10000, 21'h0abcd, 21'h1ffff, 21'h00003, 1, n);
    wait_job(n, "start in done");
    step();

    // Corners: widest grid and single lines.
    launch(1'b0, 15, 15, 21'($urandom), 21'($urandom), 21'($urandom), 21'($urandom), 0, n);
    wait_job(n, "zz15x15");
    launch(1'b0, 1, 7, 21'd5, 21'd9, 21'd3, 21'd2, 0, n);
    wait_job(n, "line 1x7");
    launch(1'b0, 7, 1, 21'd5, 21'd9, 21'd3, 21'd2, 1, n);
    wait_job(n, "line 7x1");
    launch(1'b1, 1, 1, 21'd5, 21'd9, 21'd3, 21'd2, 2, n);
    wait_job(n, "dot 1x1");
    step();

    // Random jobs.
    for (int j = 0; j < 10; j++) begin
      rand_ready = 1'($urandom_range(0, 1));
      launch(1'($urandom_range(0, 1)), $urandom_range(1, 15), $urandom_range(1, 15),
             21'($urandom), 21'($urandom), 21'($urandom), 21'($urandom),
             $urandom_range(0, 2), n);
      wait_job(n, "random");
      if ($urandom_range(0, 1) == 1) step();
    end
    rand_ready = 0;
    step();

    // clr mid-job aborts without done; a fresh job then runs fully.
    launch(1'b0, 6, 4, 21'h00100, 21'h00200, 21'h00001, 21'h00002, 0, n);
    cyc = 0;
    while (beats_job < 10 && cyc < 1000) begin
      step();
      cyc++;
    end
    chk("clr beat index", 32'(beats_job), 32'd10);
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (3) step();
    launch(1'b0, 6, 4, 21'h00100, 21'h00200, 21'h00001, 21'h00002, 0, n);
    wait_job(n, "after clr");
    chk("after clr beats literal", 32'(beats_job), 32'd24);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
